// File: rtl/seq_det_pkg.sv
// Shared types and the "11-then-0" transition function for the time-shared detector.
package seq_det_pkg;

  localparam int CNTW_DEFAULT = 16;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } det_state_e;

  typedef struct packed {
    det_state_e nxt;
    logic       hit;
  } det_step_t;

  // Encoding 3 is unreachable in normal operation; it falls into the S0 row.
  function automatic det_step_t det_step(input logic [1:0] cur, input logic x);
    det_step_t r;
    r.nxt = S0;
    r.hit = 1'b0;
    case (cur)
      2'd1: r.nxt = x ? S2 : S0;
      2'd2: begin
        r.nxt = x ? S2 : S0;
        r.hit = ~x;
      end
      default: r.nxt = x ? S1 : S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gid,
  output logic          any
);

  always_comb begin
    int idx;
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        gid        = IW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// One "11-then-0" detector time-shared across NCH serial channels with per-channel saved state.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int IDW  = $clog2(NCH),
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  in_valid,
  input  logic [NCH-1:0]  in_bit,
  output logic [NCH-1:0]  in_ready,
  input  logic [NCH-1:0]  chan_en,
  input  logic [NCH-1:0]  clr_chan,
  input  logic            cnt_clr,
  output logic            det_valid,
  output logic [IDW-1:0]  det_chan,
  output logic [CNTW-1:0] hit_cnt,
  output logic            busy
);

  det_state_e      state_q [NCH];
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic            det_valid_q;
  logic [IDW-1:0]  det_chan_q;
  logic [CNTW-1:0] hit_cnt_q;
  logic            busy_q;

  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  grant;
  logic [IDW-1:0]  gid;
  logic            xfer;
  det_step_t       step;
  logic            hit_d;

  // A channel being cleared this cycle must not also be evaluated.
  assign elig = in_valid & chan_en & ~clr_chan;

  rr_arbiter #(
    .N  (NCH),
    .IW (IDW)
  ) u_arb (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .gid   (gid),
    .any   (xfer)
  );

  assign in_ready = grant;
  assign step     = det_step(state_q[gid], in_bit[gid]);
  assign hit_d    = xfer & step.hit;
  assign rr_ptr_d = (int'(gid) == NCH - 1) ? '0 : IDW'(int'(gid) + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= S0;
      rr_ptr_q    <= '0;
      det_valid_q <= 1'b0;
      det_chan_q  <= '0;
      hit_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr_chan[i]) state_q[i] <= S0;
        else if (xfer && (gid == IDW'(i))) state_q[i] <= step.nxt;
      end
      if (xfer) rr_ptr_q <= rr_ptr_d;
      det_valid_q <= hit_d;
      if (hit_d) det_chan_q <= gid;
      busy_q <= xfer;
      // Clear has priority over a coincident hit; the count saturates instead of wrapping.
      if (cnt_clr) hit_cnt_q <= '0;
      else if (hit_d && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign det_valid = det_valid_q;
  assign det_chan  = det_chan_q;
  assign hit_cnt   = hit_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed scenarios plus random traffic against a run-length reference model.
module tb_seq_det_scheduler;

  localparam int NCH  = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            reset;
  logic [NCH-1:0]  in_valid;
  logic [NCH-1:0]  in_bit;
  logic [NCH-1:0]  in_ready;
  logic [NCH-1:0]  chan_en;
  logic [NCH-1:0]  clr_chan;
  logic            cnt_clr;
  logic            det_valid;
  logic [IDW-1:0]  det_chan;
  logic [CNTW-1:0] hit_cnt;
  logic            busy;

  seq_det_scheduler #(.NCH(NCH), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .chan_en   (chan_en),
    .clr_chan  (clr_chan),
    .cnt_clr   (cnt_clr),
    .det_valid (det_valid),
    .det_chan  (det_chan),
    .hit_cnt   (hit_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: each channel remembers how many consecutive 1s it has accepted.
  int ones_run [NCH];
  int ptr_m;
  int dv_m;
  int dc_m;
  int cnt_m;
  int busy_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) ones_run[i] = 0;
    ptr_m = 0; dv_m = 0; dc_m = 0; cnt_m = 0; busy_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = '0; in_bit = '0; clr_chan = '0; cnt_clr = 1'b0; chan_en = '1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_det_valid", 32'(det_valid), 0);
    check_eq("rst_det_chan", 32'(det_chan), 0);
    check_eq("rst_hit_cnt", 32'(hit_cnt), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] en, input logic [NCH-1:0] clr, input logic cc);
    int g;
    int hit;
    int idx;
    logic [NCH-1:0] exp_ready;
    @(negedge clk);
    in_valid = v; in_bit = b; chan_en = en; clr_chan = clr; cnt_clr = cc;
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      idx = (ptr_m + k) % NCH;
      if (g < 0 && v[idx] && en[idx] && !clr[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    hit = 0;
    if (g >= 0) begin
      if (!b[g] && ones_run[g] >= 2) hit = 1;
      ones_run[g] = b[g] ? ones_run[g] + 1 : 0;
      ptr_m = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) if (clr[i]) ones_run[i] = 0;
    dv_m   = hit;
    if (hit != 0) dc_m = g;
    busy_m = (g >= 0) ? 1 : 0;
    if (cc) cnt_m = 0;
    else if (hit != 0 && cnt_m < CMAX) cnt_m++;
    @(posedge clk);
    #1;
    check_eq("det_valid", 32'(det_valid), 32'(dv_m));
    if (dv_m != 0) check_eq("det_chan", 32'(det_chan), 32'(dc_m));
    check_eq("hit_cnt", 32'(hit_cnt), 32'(cnt_m));
    check_eq("busy", 32'(busy), 32'(busy_m));
  endtask

  task automatic send(input int ch, input logic x);
    logic [NCH-1:0] v;
    logic [NCH-1:0] b;
    v = '0; b = '0;
    v[ch] = 1'b1; b[ch] = x;
    step(v, b, 4'hF, 4'h0, 1'b0);
  endtask

  initial begin
    logic [NCH-1:0] rv, rb, ren, rclr;
    logic rcc;
    reset = 1'b1;
    in_valid = '0; in_bit = '0; chan_en = '1; clr_chan = '0; cnt_clr = 1'b0;
    model_reset();
    do_reset();

    // Single-channel patterns on ch2
    send(2, 1); send(2, 1); send(2, 0);
    send(2, 1); send(2, 1); send(2, 1); send(2, 0);
    send(2, 1); send(2, 0); send(2, 1); send(2, 1); send(2, 0);

    // Fairness and interleaved hits on every channel
    do_reset();
    for (int i = 0; i < 8; i++) step(4'hF, 4'hF, 4'hF, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(4'hF, 4'h0, 4'hF, 4'h0, 1'b0);

    // Isolation: ch1 traffic between ch0's 1,1 and 0
    send(0, 1); send(0, 1); send(1, 0); send(0, 0);
    // Clear of ch0 after 1,1 while it is also requesting
    send(0, 1); send(0, 1);
    step(4'h1, 4'h0, 4'hF, 4'h1, 1'b0);
    send(0, 0);

    // Enable gating on ch3
    send(3, 1); send(3, 1);
    for (int i = 0; i < 3; i++) step(4'h8, 4'h0, 4'h7, 4'h0, 1'b0);
    step(4'h8, 4'h0, 4'hF, 4'h0, 1'b0);

    // Counter saturation and clear coincident with a hit
    for (int i = 0; i < 17; i++) begin send(1, 1); send(1, 1); send(1, 0); end
    send(1, 1); send(1, 1);
    step(4'h2, 4'h0, 4'hF, 4'h0, 1'b1);

    // Reset between bits 2 and 3 of a pattern
    send(2, 1); send(2, 1);
    do_reset();
    send(2, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rv   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      ren  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      rclr = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      rcc  = ($urandom_range(0, 63) == 0);
      step(rv, rb, ren, rclr, rcc);
      if (i % 200 == 150) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
